// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_ctrl_pkg;

  typedef enum logic {
    StRun   = 1'b0,
    StFlush = 1'b1
  } ctrl_state_e;

  localparam int unsigned DefNReq      = 4;
  localparam int unsigned DefWordDepth = 8;

  // Sticky error flag positions.
  localparam int unsigned ErrOvfBit = 0;
  localparam int unsigned ErrMisBit = 1;

  // One slot is always sacrificed by the FIFO's pointer scheme.
  function automatic int unsigned cap_of(int unsigned depth);
    return depth - 1;
  endfunction

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority search: first valid requester after last_i, wrapping around.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    grant_oh_o,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            any_o
);

  // Scan last_i+1 .. last_i+N; the requester just served is checked last.
  always_comb begin
    int unsigned cand;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % N;
      if (!any_o && valid_i[cand[IdxW-1:0]]) begin
        any_o                          = 1'b1;
        grant_idx_o                    = cand[IdxW-1:0];
        grant_oh_o[cand[IdxW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter and flush sequencer in front of the 12-bit FIFO-SRAM.
// Tracks a shadow occupancy so the FIFO is never written while full.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NREQ       = DefNReq,
  parameter int unsigned BITS       = 12,
  parameter int unsigned word_depth = DefWordDepth,
  parameter int unsigned addr_width = 3,
  localparam int unsigned IdxW      = idx_width(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*BITS-1:0]   req_data_i,
  input  logic                   cons_read_i,
  input  logic                   flush_i,
  output logic                   fifo_write_o,
  output logic [BITS-1:0]        fifo_data_in_o,
  output logic                   fifo_read_o,
  input  logic                   fifo_ready_i,
  input  logic                   fifo_overflow_i,
  output logic [addr_width:0]    level_o,
  output logic                   full_o,
  output logic [IdxW-1:0]        grant_id_o,
  output logic                   flush_busy_o,
  output logic [1:0]             err_o
);

  localparam int unsigned LvlW = addr_width + 1;
  localparam logic [LvlW-1:0] CapLvl  = LvlW'(cap_of(word_depth));
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

  ctrl_state_e     state_q, state_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [1:0]      err_q, err_d;

  logic [NREQ-1:0] pick_oh;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic            is_full, in_run, push, pop, dec;

  rr_pick #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .valid_i     (req_valid_i),
    .last_i      (last_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  // Same-cycle grant and FIFO write/read muxing. Full is judged on the
  // registered level only: a concurrent pop does not free a slot.
  always_comb begin
    is_full        = (level_q == CapLvl);
    in_run         = (state_q == StRun);
    push           = in_run && !is_full && pick_any;
    req_ready_o    = '0;
    fifo_data_in_o = '0;
    if (push) begin
      req_ready_o    = pick_oh;
      fifo_data_in_o = req_data_i[pick_idx*BITS +: BITS];
    end
    fifo_write_o = push;
    fifo_read_o  = in_run ? cons_read_i : 1'b1;
    pop          = fifo_read_o && fifo_ready_i;
    // A pop reported at level 0 is a mismatch; never let it wrap the count.
    dec          = pop && (level_q != '0);
  end

  // Next-state: shadow level, grant pointers, drain FSM, sticky errors.
  always_comb begin
    level_d = level_q;
    unique case ({push, dec})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    last_d  = last_q;
    grant_d = grant_q;
    if (push) begin
      last_d  = pick_idx;
      grant_d = pick_idx;
    end

    state_d = state_q;
    case (state_q)
      StRun:   if (flush_i) state_d = StFlush;
      StFlush: if (level_q == '0) state_d = StRun;
      default: state_d = StRun;
    endcase

    err_d            = err_q;
    err_d[ErrOvfBit] = err_q[ErrOvfBit] | fifo_overflow_i;
    err_d[ErrMisBit] = err_q[ErrMisBit] | (fifo_ready_i != (level_q != '0));
  end

  // State registers with synchronous reset; last_q starts at NREQ-1 so producer 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      level_q <= '0;
      last_q  <= LastIdx;
      grant_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  // Registered status outputs.
  always_comb begin
    level_o      = level_q;
    full_o       = is_full;
    grant_id_o   = grant_q;
    flush_busy_o = (state_q == StFlush);
    err_o        = err_q;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter with a behavioural FIFO-SRAM model.
module tb_fifo_write_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned BITS = 12;
  localparam int unsigned WD   = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned IdxW = 2;
  localparam int unsigned CAP  = WD - 1;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_data;
  logic                 cons_read;
  logic                 flush;
  logic                 fifo_write;
  logic [BITS-1:0]      fifo_data_in;
  logic                 fifo_read;
  logic                 fifo_ready;
  logic                 fifo_overflow;
  logic [AW:0]          level;
  logic                 full;
  logic [IdxW-1:0]      grant_id;
  logic                 flush_busy;
  logic [1:0]           err;

  always #5 clk_i = ~clk_i;

  fifo_write_arbiter #(
    .NREQ       (NREQ),
    .BITS       (BITS),
    .word_depth (WD),
    .addr_width (AW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_data_i      (req_data),
    .cons_read_i     (cons_read),
    .flush_i         (flush),
    .fifo_write_o    (fifo_write),
    .fifo_data_in_o  (fifo_data_in),
    .fifo_read_o     (fifo_read),
    .fifo_ready_i    (fifo_ready),
    .fifo_overflow_i (fifo_overflow),
    .level_o         (level),
    .full_o          (full),
    .grant_id_o      (grant_id),
    .flush_busy_o    (flush_busy),
    .err_o           (err)
  );

  // Behavioural FIFO-SRAM: show-ahead output, one slot unusable, overflow on write when full.
  logic [BITS-1:0] fmem [WD];
  int unsigned     f_wr, f_rd, f_cnt;
  logic            force_ovf, force_ready;
  logic            f_full, f_do_w, f_do_r, f_ovf_raw;
  logic [BITS-1:0] f_dout;

  assign f_full        = (f_cnt == CAP);
  assign f_do_w        = fifo_write && !f_full;
  assign f_do_r        = fifo_read && (f_cnt != 0);
  assign f_ovf_raw     = fifo_write && f_full;
  assign fifo_ready    = (f_cnt != 0) || force_ready;
  assign fifo_overflow = f_ovf_raw || force_ovf;
  assign f_dout        = fmem[f_rd];

  always @(posedge clk_i) begin
    if (rst_i) begin
      f_wr  <= 0;
      f_rd  <= 0;
      f_cnt <= 0;
    end else begin
      if (f_do_w) begin
        fmem[f_wr] <= fifo_data_in;
        f_wr       <= (f_wr + 1) % WD;
      end
      if (f_do_r) f_rd <= (f_rd + 1) % WD;
      f_cnt <= f_cnt + (f_do_w ? 1 : 0) - (f_do_r ? 1 : 0);
    end
  end

  int unsigned ovf_seen = 0;
  always @(posedge clk_i) begin
    if (!rst_i && f_ovf_raw) ovf_seen <= ovf_seen + 1;
  end

  logic [BITS-1:0] sb_q [$];
  int unsigned     n_checks = 0;
  int unsigned     n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [BITS-1:0] pdata(input int unsigned i, input int unsigned c);
    return BITS'((i << 8) | (c & 255));
  endfunction

  task automatic set_data(input int unsigned c);
    for (int unsigned i = 0; i < NREQ; i++) req_data[i*BITS +: BITS] = pdata(i, c);
  endtask

  // Compare the word leaving the FIFO this cycle against the scoreboard head.
  task automatic check_pop(input string tag);
    logic [31:0] exp;
    if (fifo_read && fifo_ready) begin
      if (sb_q.size() != 0) exp = 32'(sb_q.pop_front());
      else                  exp = 32'hFFFF_FFFF;
      check_eq(tag, 32'(f_dout), exp);
    end
  endtask

  task automatic run_flush(input string tag, input int unsigned exp_cycles,
                           input logic [NREQ-1:0] valid_in_flush);
    int unsigned busy;
    busy  = 0;
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    req_valid = valid_in_flush;
    cons_read = 1'b0;
    settle();
    while (flush_busy && busy < 20) begin
      busy++;
      check_eq({tag, "_ready"}, 32'(req_ready), 0);
      check_eq({tag, "_rd"}, 32'(fifo_read), 1);
      check_pop({tag, "_data"});
      tick();
      settle();
    end
    req_valid = '0;
    settle();
    check_eq({tag, "_cycles"}, busy, exp_cycles);
    check_eq({tag, "_level"}, 32'(level), 0);
    check_eq({tag, "_sb_left"}, sb_q.size(), 0);
    check_eq({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    int unsigned w;
    rst_i       = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    cons_read   = 1'b0;
    flush       = 1'b0;
    force_ovf   = 1'b0;
    force_ready = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    settle();

    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_busy", 32'(flush_busy), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_grant_id", 32'(grant_id), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_write", 32'(fifo_write), 0);
    check_eq("rst_read", 32'(fifo_read), 0);
    check_eq("rst_data_in", 32'(fifo_data_in), 0);

    // All producers valid, no pops: round-robin 0,1,2,3,0,1,2 then full.
    req_valid = '1;
    for (int unsigned c = 0; c < CAP; c++) begin
      set_data(c);
      settle();
      w = c % NREQ;
      check_eq("fill_ready", 32'(req_ready), 32'(1) << w);
      check_eq("fill_data", 32'(fifo_data_in), 32'(pdata(w, c)));
      check_eq("fill_level", 32'(level), c);
      sb_q.push_back(pdata(w, c));
      tick();
    end
    settle();
    check_eq("full_flag", 32'(full), 1);
    check_eq("full_ready", 32'(req_ready), 0);
    check_eq("full_write", 32'(fifo_write), 0);
    check_eq("full_level", 32'(level), CAP);
    check_eq("full_err", 32'(err), 0);
    check_eq("full_grant_id", 32'(grant_id), 2);

    // Pop at full: no push in the same cycle, slot is reusable next cycle.
    req_valid = 4'b0001;
    cons_read = 1'b1;
    set_data(20);
    settle();
    check_eq("fullpop_ready", 32'(req_ready), 0);
    check_eq("fullpop_write", 32'(fifo_write), 0);
    check_eq("fullpop_read", 32'(fifo_read), 1);
    check_pop("fullpop_data");
    tick();
    cons_read = 1'b0;
    settle();
    check_eq("afterpop_level", 32'(level), CAP - 1);
    check_eq("afterpop_full", 32'(full), 0);
    check_eq("afterpop_ready", 32'(req_ready), 32'b0001);
    check_eq("afterpop_data", 32'(fifo_data_in), 32'(pdata(0, 20)));
    sb_q.push_back(pdata(0, 20));
    tick();
    settle();
    check_eq("refill_level", 32'(level), CAP);
    check_eq("refill_grant_id", 32'(grant_id), 0);

    // Drain everything; producers held valid but must be refused while draining.
    run_flush("drain7", CAP + 1, '1);

    // Queue 0xA01..0xA03 from producer 0, then flush with level 3.
    req_data = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      req_valid           = 4'b0001;
      req_data[0 +: BITS] = BITS'(12'hA01 + k);
      settle();
      check_eq("a0x_ready", 32'(req_ready), 32'b0001);
      check_eq("a0x_data", 32'(fifo_data_in), 32'(12'hA01 + k));
      sb_q.push_back(BITS'(12'hA01 + k));
      tick();
    end
    req_valid = '0;
    settle();
    check_eq("a0x_level", 32'(level), 3);
    run_flush("flush3", 4, '1);

    // Producers 1 and 3 only, after producer 1 was last served: 3,1,3,1.
    req_valid = 4'b0010;
    set_data(40);
    settle();
    check_eq("p1_seed_ready", 32'(req_ready), 32'b0010);
    sb_q.push_back(pdata(1, 40));
    tick();
    req_valid = 4'b1010;
    for (int unsigned j = 0; j < 4; j++) begin
      set_data(41 + j);
      settle();
      w = (j % 2 == 0) ? 3 : 1;
      check_eq("alt_ready", 32'(req_ready), 32'(1) << w);
      check_eq("alt_data", 32'(fifo_data_in), 32'(pdata(w, 41 + j)));
      sb_q.push_back(pdata(w, 41 + j));
      tick();
    end
    settle();
    check_eq("alt_level", 32'(level), 5);
    check_eq("alt_grant_id", 32'(grant_id), 1);

    // Reset at level 5 with requests active; arbitration restarts at producer 0.
    rst_i     = 1'b1;
    req_valid = '1;
    tick();
    rst_i = 1'b0;
    sb_q.delete();
    settle();
    check_eq("mid_rst_level", 32'(level), 0);
    check_eq("mid_rst_full", 32'(full), 0);
    check_eq("mid_rst_busy", 32'(flush_busy), 0);
    check_eq("mid_rst_err", 32'(err), 0);
    check_eq("mid_rst_grant_id", 32'(grant_id), 0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'b0001);
    check_eq("mid_rst_write", 32'(fifo_write), 1);
    req_valid = '0;
    settle();

    // Sticky error flags.
    force_ovf = 1'b1;
    settle();
    check_eq("err_pre_ovf", 32'(err), 0);
    tick();
    force_ovf = 1'b0;
    settle();
    check_eq("err_ovf_set", 32'(err), 32'b01);
    tick();
    tick();
    settle();
    check_eq("err_ovf_hold", 32'(err), 32'b01);
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    settle();
    check_eq("err_mis_set", 32'(err), 32'b11);
    tick();
    settle();
    check_eq("err_mis_hold", 32'(err), 32'b11);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    check_eq("err_cleared", 32'(err), 0);
    check_eq("fifo_ovf_never", ovf_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter and sequencer in front of one instance of the team's 12-bit FIFO-SRAM.
- Shares the FIFO write port between NREQ producers through valid/ready handshakes.
- Keeps a shadow occupancy count so the FIFO is never written when full; its overflow flag must never rise.
- Passes consumer pops through to the FIFO, and provides a flush mode that drains the FIFO under controller control.

Parameters:
- NREQ, 4, number of producers (2..8)
- BITS, 12, data width; must match the FIFO
- word_depth, 8, FIFO depth; usable capacity CAP = word_depth-1
- addr_width, 3, log2(word_depth)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  producer i has a word
- req_ready  out  NREQ  producer i word accepted this cycle (one-hot or zero)
- req_data  in  NREQ*BITS  producer i data at bits [i*BITS +: BITS]
- cons_read  in  1  consumer pop request (RUN state only)
- flush  in  1  start a drain (pulse)
- fifo_write  out  1  to FIFO write
- fifo_data_in  out  BITS  to FIFO data_in
- fifo_read  out  1  to FIFO read
- fifo_ready  in  1  from FIFO ready (has data)
- fifo_overflow  in  1  from FIFO overflow
- level  out  addr_width+1  shadow occupancy, 0..CAP
- full  out  1  level == CAP
- grant_id  out  $clog2(NREQ)  index of the last accepted producer
- flush_busy  out  1  state == FLUSH
- err  out  2  sticky: [0] overflow seen, [1] shadow/FIFO mismatch

Behaviour:
- Reset (rst=1 at a clk edge) applies to all state:
  - level=0, state=RUN, last_grant=NREQ-1 (producer 0 wins first), grant_id=0, err=0.
  - All combinational outputs then evaluate to 0.
- Reset mid-operation resets only the arbiter. The FIFO must share rst (inverted to its rst_n) so both empty together.
- States are RUN and FLUSH.
- Arbitration (combinational, RUN only, !full):
  - Winner is the first i with req_valid[i], searching circularly from last_grant+1.
  - req_ready[winner]=1, fifo_write=1, fifo_data_in=req_data[winner], all in the same cycle (zero latency).
  - On accept, last_grant and grant_id take the winner index at the next edge.
  - With no valid request, or when full or in FLUSH: req_ready=0 and fifo_write=0. fifo_data_in is don't-care and is driven 0.
- Full rule:
  - full uses the registered level only.
  - A pop in the same cycle does NOT free a slot, because the FIFO checks its pointers before the pop applies.
- Pop:
  - fifo_read = cons_read in RUN, and 1 in FLUSH.
  - pop = fifo_read && fifo_ready.
- Level update: level <= level + push - pop.
  - Simultaneous push and pop leaves level unchanged.
  - Width addr_width+1; never exceeds CAP, never wraps below 0.
- Flush:
  - flush=1 in RUN moves to FLUSH at the next edge. A push in that same cycle still completes.
  - flush is ignored while in FLUSH.
  - FLUSH returns to RUN at the edge after the cycle where level==0.
  - With level L at entry, flush_busy lasts L+1 cycles.
  - cons_read is ignored in FLUSH.
- Errors:
  - err[0] sets when fifo_overflow=1.
  - err[1] sets when fifo_ready != (level!=0).
  - Both are sampled every cycle and stay set until rst.
- Fairness: a continuously valid producer is granted within NREQ accepts.

Decomposition:
- Shared package fifo_ctrl_pkg holds:
  - state enum {RUN, FLUSH}
  - CAP = word_depth-1
  - index width localparam
  - err bit positions
- One sub-module rr_pick: combinational circular priority search taking (valid, last_grant) and returning (grant_onehot, grant_idx, any).
- The top holds the level counter, FSM, muxes and error logic.

Test Plan:
- Reset, then req_valid=4'b1111 held with no pops:
  - Accepts go in order 0,1,2,3,0,1,2 (7 accepts), then full=1 and req_ready=0.
  - level=7, err=0, fifo_overflow never 1.
- Level 7 with cons_read=1 and req_valid=4'b0001 both held for one cycle:
  - No push that cycle (full), one pop, level becomes 6.
  - The next cycle accepts producer 0, level returns to 7.
- Level 3, data 0xA01/0xA02/0xA03 queued, flush pulse:
  - fifo_read=1 for 3 pops, data_out sequence 0xA01, 0xA02, 0xA03.
  - flush_busy high for 4 cycles, then RUN with level=0.
  - req_valid held during flush gets req_ready=0 throughout.
- Producers 1 and 3 valid only, last_grant=1:
  - Grants go 3,1,3,1.
  - fifo_data_in matches the granted producer's req_data each cycle.
- Level 5, rst=1 asserted for one edge with req_valid active:
  - The next cycle shows level=0, full=0, flush_busy=0, err=0, and arbitration restarts at producer 0.
- Force fifo_overflow=1 for one cycle, or fifo_ready=1 at level 0:
  - err[0], or err[1] respectively, sets and holds until rst.
